debounce_edge: RTL and testbench

DEBOUNCE_EDGE -- requirements
Module: debounce_edge

---
 rtl/debounce_edge.sv | 111 +++++++++++
 tb/tb_debounce_edge.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/debounce_edge.sv
// Debounces an asynchronous level: two-flop synchronizer, then a stability counter
// that lets q follow only after STABLE_CYCLES consecutive enabled mismatching cycles.
module debounce_edge #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall,
    output logic busy
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_COUNT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             r_s1;
    logic             r_s2;
    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_q;
    logic             w_q_nxt;
    logic             r_rise;
    logic             r_fall;
    logic             w_known;
    logic             w_mismatch;

    // Synchronizer stage: d is only ever seen through r_s2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= d;
            r_s2 <= r_s1;
        end
    end

    // An unknown synchronizer output is treated as agreeing with q, so it can never flip q.
    assign w_known    = (r_s2 === 1'b0) || (r_s2 === 1'b1);
    assign w_mismatch = w_known && (r_s2 != r_q);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_q_nxt     = r_q;
        if (en) begin
            if (w_mismatch) begin
                case (r_state)
                    ST_IDLE: begin
                        if (STABLE_CYCLES == 1) begin
                            w_q_nxt = ~r_q;
                        end else begin
                            w_cnt_nxt   = CNT_W'(1);
                            w_state_nxt = ST_COUNT;
                        end
                    end
                    ST_COUNT: begin
                        // >= rather than == so a corrupted count still terminates instead of wrapping.
                        if (r_cnt >= LP_LAST) begin
                            w_q_nxt     = ~r_q;
                            w_cnt_nxt   = '0;
                            w_state_nxt = ST_IDLE;
                        end else begin
                            w_cnt_nxt = r_cnt + CNT_W'(1);
                        end
                    end
                    default: begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = ST_IDLE;
                    end
                endcase
            end else begin
                w_cnt_nxt   = '0;
                w_state_nxt = ST_IDLE;
            end
        end
    end

    // State/output register stage: edge pulses are registered alongside the q update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_q     <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_q     <= w_q_nxt;
            r_rise  <= w_q_nxt & ~r_q;
            r_fall  <= ~w_q_nxt & r_q;
        end
    end

    assign q    = r_q;
    assign rise = r_rise;
    assign fall = r_fall;
    assign busy = (r_cnt != '0);

endmodule

// File: tb/tb_debounce_edge.sv
// Directed bench for debounce_edge: default-parameter instance driven from a vector
// table plus hand sequences, and a STABLE_CYCLES=1 instance for the fast-follow case.
module tb_debounce_edge;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic en0, d0, q0, rise0, fall0, busy0;
    logic en1, d1, q1, rise1, fall1, busy1;

    int checks = 0;
    int errors = 0;

    debounce_edge #(.STABLE_CYCLES(4), .CNT_W(4)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .en(en0), .d(d0),
        .q(q0), .rise(rise0), .fall(fall0), .busy(busy0)
    );

    debounce_edge #(.STABLE_CYCLES(1), .CNT_W(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .en(en1), .d(d1),
        .q(q1), .rise(rise1), .fall(fall1), .busy(busy1)
    );

    typedef struct packed {
        logic en;
        logic d;
        logic q;
        logic rise;
        logic fall;
        logic busy;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic en, input logic d, input logic [3:0] exp);
        vec_t v;
        v.en   = en;
        v.d    = d;
        v.q    = exp[3];
        v.rise = exp[2];
        v.fall = exp[1];
        v.busy = exp[0];
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: q,rise,fall,busy got %b want %b", name, got, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
    task automatic step0(input logic en, input logic d);
        @(negedge clk);
        en0 = en;
        d0  = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic dseq[28];
        logic qexp[28];
        logic qprev;

        // Rows: {en, d, expected q/rise/fall/busy after that edge}; state carries row to row.
        // Reset then d=1: q rises on the 6th edge that sees d (edge k+5), busy on edges k+2..k+4.
        add(1, 1, 4'b0000); add(1, 1, 4'b0000); add(1, 1, 4'b0001); add(1, 1, 4'b0001);
        add(1, 1, 4'b0001); add(1, 1, 4'b1100); add(1, 1, 4'b1000); add(1, 1, 4'b1000);
        // Two-cycle low glitch while q=1: count reaches 2 only, then drops back.
        add(1, 0, 4'b1000); add(1, 0, 4'b1000); add(1, 1, 4'b1001); add(1, 1, 4'b1001);
        add(1, 1, 4'b1000); add(1, 1, 4'b1000);
        // Count reaches 2, en low for 3 cycles freezes it, then 2 enabled cycles to flip.
        add(1, 0, 4'b1000); add(1, 0, 4'b1000); add(1, 0, 4'b1001); add(1, 0, 4'b1001);
        add(0, 0, 4'b1001); add(0, 0, 4'b1001); add(0, 0, 4'b1001);
        add(1, 0, 4'b1001); add(1, 0, 4'b0010); add(1, 0, 4'b0000);
        // Unknown input for 6 cycles never counts as a mismatch.
        for (int i = 0; i < 6; i++) add(1, 1'bx, 4'b0000);
        add(1, 0, 4'b0000); add(1, 0, 4'b0000);
        // en low while synchronized input differs: nothing counts, then 4 enabled cycles flip q.
        add(0, 1, 4'b0000); add(0, 1, 4'b0000); add(0, 1, 4'b0000);
        add(1, 1, 4'b0001); add(1, 1, 4'b0001); add(1, 1, 4'b0001); add(1, 1, 4'b1100);
        add(1, 1, 4'b1000);
        // Normal fall path.
        add(1, 0, 4'b1000); add(1, 0, 4'b1000); add(1, 0, 4'b1001); add(1, 0, 4'b1001);
        add(1, 0, 4'b1001); add(1, 0, 4'b0010); add(1, 0, 4'b0000);

        rst_n = 1'b0;
        en0   = 1'b0;
        d0    = 1'b0;
        en1   = 1'b1;
        d1    = 1'b0;
        #1;
        check("reset0", {q0, rise0, fall0, busy0}, 4'b0000);
        check("reset1", {q1, rise1, fall1, busy1}, 4'b0000);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            step0(vecs[i].en, vecs[i].d);
            check($sformatf("vec%0d", i), {q0, rise0, fall0, busy0},
                  {vecs[i].q, vecs[i].rise, vecs[i].fall, vecs[i].busy});
        end

        // Asynchronous reset mid-count: count=3 is discarded without any clock edge.
        for (int i = 1; i <= 5; i++) step0(1'b1, 1'b1);
        check("precount", {q0, rise0, fall0, busy0}, 4'b0001);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("async_rst", {q0, rise0, fall0, busy0}, 4'b0000);
        #1;
        rst_n = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("postrst%0d", i), {q0, rise0, fall0, busy0},
                  {(i >= 6) ? 1'b1 : 1'b0, (i == 6) ? 1'b1 : 1'b0, 1'b0,
                   (i >= 3 && i <= 5) ? 1'b1 : 1'b0});
        end

        // STABLE_CYCLES=1: q follows the input 2 edges after the first edge that sees it.
        for (int i = 0; i < 28; i++) dseq[i] = ((i / 4) % 2) == 1;
        qprev = 1'b0;
        for (int i = 0; i < 28; i++) begin
            qexp[i] = (i >= 2) ? dseq[i-2] : 1'b0;
            @(negedge clk);
            d1 = dseq[i];
            @(posedge clk);
            #1;
            check($sformatf("fast%0d", i), {q1, rise1, fall1, busy1},
                  {qexp[i], qexp[i] & ~qprev, ~qexp[i] & qprev, 1'b0});
            qprev = qexp[i];
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
